// File: rtl/lsu_stage_if.sv
// Data-memory request/acknowledge bus between the load/store stage and memory.
interface lsu_stage_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        ack;
  logic [31:0] rdata;

  modport master (output req, output we, output addr, output be, output wdata,
                  input ack, input rdata);
  modport slave  (input req, input we, input addr, input be, input wdata,
                  output ack, output rdata);
endinterface

// File: rtl/lsu_stage.sv
// Execute-to-writeback stage: forwards ALU results, runs one data-memory
// transaction per load/store with lane steering, extension and a bus timeout.
module lsu_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ex_valid,
  output logic         ex_ready,
  input  logic         ex_is_load,
  input  logic         ex_is_store,
  input  logic [2:0]   ex_funct3,
  input  logic [31:0]  ex_addr,
  input  logic [31:0]  ex_wdata,
  input  logic [4:0]   ex_rd,
  lsu_stage_if.master  dmem,
  output logic         wb_valid,
  output logic [4:0]   wb_rd,
  output logic [31:0]  wb_data,
  output logic         exc_valid,
  output logic [31:0]  exc_addr
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]  state_r;
  logic [31:0] addr_r;
  logic [2:0]  funct3_r;
  logic [4:0]  rd_r;
  logic [31:0] tmo_cnt_r;
  logic        is_mem_s;
  logic        illegal_s;
  logic        misaligned_s;
  logic        tmo_hit_s;

  function automatic logic [3:0] lane_be(input logic [1:0] sz, input logic [1:0] a);
    logic [3:0] be;
    case (sz)
      2'b00:   be = 4'b0001 << a;
      2'b01:   be = a[1] ? 4'b1100 : 4'b0011;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] lane_wdata(input logic [1:0] sz, input logic [31:0] d);
    logic [31:0] w;
    case (sz)
      2'b00:   w = {4{d[7:0]}};
      2'b01:   w = {2{d[15:0]}};
      default: w = d;
    endcase
    return w;
  endfunction

  // Byte/halfword results come from the addressed lane, then get extended.
  function automatic logic [31:0] load_extract(input logic [2:0] f3, input logic [1:0] a,
                                               input logic [31:0] rdata);
    logic [31:0] s;
    logic [31:0] r;
    s = rdata >> {a, 3'b000};
    case (f3)
      3'b000:  r = {{24{s[7]}}, s[7:0]};
      3'b001:  r = {{16{s[15]}}, s[15:0]};
      3'b100:  r = {24'h000000, s[7:0]};
      3'b101:  r = {16'h0000, s[15:0]};
      default: r = s;
    endcase
    return r;
  endfunction

  assign ex_ready  = (state_r == IDLE) && !rst;
  assign tmo_hit_s = (TIMEOUT_CYCLES != 32'd0) && ((tmo_cnt_r + 32'd1) == TIMEOUT_CYCLES);

  // Decode the incoming op into legality and alignment faults.
  always_comb begin
    is_mem_s     = ex_is_load || ex_is_store;
    illegal_s    = 1'b0;
    misaligned_s = 1'b0;
    if (ex_is_load && ex_is_store) begin
      illegal_s = 1'b1;
    end else if (ex_is_load) begin
      case (ex_funct3)
        3'b011, 3'b110, 3'b111: illegal_s = 1'b1;
        default:                illegal_s = 1'b0;
      endcase
    end else if (ex_is_store) begin
      case (ex_funct3)
        3'b000, 3'b001, 3'b010: illegal_s = 1'b0;
        default:                illegal_s = 1'b1;
      endcase
    end else begin
      illegal_s = 1'b0;
    end
    case (ex_funct3[1:0])
      2'b01:   misaligned_s = is_mem_s && ex_addr[0];
      2'b10:   misaligned_s = is_mem_s && (ex_addr[1:0] != 2'b00);
      default: misaligned_s = 1'b0;
    endcase
  end

  // Stage FSM, memory request and writeback/exception pulse registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      addr_r     <= 32'd0;
      funct3_r   <= 3'd0;
      rd_r       <= 5'd0;
      tmo_cnt_r  <= 32'd0;
      dmem.req   <= 1'b0;
      dmem.we    <= 1'b0;
      dmem.addr  <= 32'd0;
      dmem.be    <= 4'd0;
      dmem.wdata <= 32'd0;
      wb_valid   <= 1'b0;
      wb_rd      <= 5'd0;
      wb_data    <= 32'd0;
      exc_valid  <= 1'b0;
      exc_addr   <= 32'd0;
    end else begin
      wb_valid  <= 1'b0;
      exc_valid <= 1'b0;
      case (state_r)
        IDLE: begin
          if (ex_valid) begin
            if (!is_mem_s) begin
              wb_valid <= 1'b1;
              wb_data  <= ex_addr;
              wb_rd    <= ex_rd;
            end else if (illegal_s || misaligned_s) begin
              exc_valid <= 1'b1;
              exc_addr  <= ex_addr;
            end else begin
              state_r    <= BUSY;
              addr_r     <= ex_addr;
              funct3_r   <= ex_funct3;
              rd_r       <= ex_rd;
              tmo_cnt_r  <= 32'd0;
              dmem.req   <= 1'b1;
              dmem.we    <= ex_is_store;
              dmem.addr  <= {ex_addr[31:2], 2'b00};
              dmem.be    <= lane_be(ex_funct3[1:0], ex_addr[1:0]);
              dmem.wdata <= ex_is_store ? lane_wdata(ex_funct3[1:0], ex_wdata) : 32'd0;
            end
          end
        end
        BUSY: begin
          // An ack on the timeout edge still completes normally.
          if (dmem.ack) begin
            state_r  <= IDLE;
            dmem.req <= 1'b0;
            if (!dmem.we) begin
              wb_valid <= 1'b1;
              wb_rd    <= rd_r;
              wb_data  <= load_extract(funct3_r, addr_r[1:0], dmem.rdata);
            end
          end else if (tmo_hit_s) begin
            state_r   <= IDLE;
            dmem.req  <= 1'b0;
            exc_valid <= 1'b1;
            exc_addr  <= addr_r;
          end else begin
            tmo_cnt_r <= tmo_cnt_r + 32'd1;
          end
        end
        default: begin
          state_r  <= IDLE;
          dmem.req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_stage.sv
// Directed self-checking bench for lsu_stage with a short bus timeout.
module tb_lsu_stage;
  logic        clk;
  logic        rst;
  logic        ex_valid;
  logic        ex_ready;
  logic        ex_is_load;
  logic        ex_is_store;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr;
  logic [31:0] ex_wdata;
  logic [4:0]  ex_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        exc_valid;
  logic [31:0] exc_addr;
  int          n_checks;
  int          n_errors;

  lsu_stage_if dmem ();

  lsu_stage #(.TIMEOUT_CYCLES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .ex_ready   (ex_ready),
    .ex_is_load (ex_is_load),
    .ex_is_store(ex_is_store),
    .ex_funct3  (ex_funct3),
    .ex_addr    (ex_addr),
    .ex_wdata   (ex_wdata),
    .ex_rd      (ex_rd),
    .dmem       (dmem.master),
    .wb_valid   (wb_valid),
    .wb_rd      (wb_rd),
    .wb_data    (wb_data),
    .exc_valid  (exc_valid),
    .exc_addr   (exc_addr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one op for a single accept edge; returns in the cycle after accept.
  task automatic issue(input logic ld, input logic st, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd);
    ex_is_load  = ld;
    ex_is_store = st;
    ex_funct3   = f3;
    ex_addr     = a;
    ex_wdata    = d;
    ex_rd       = rd;
    ex_valid    = 1'b1;
    tick();
    ex_valid    = 1'b0;
  endtask

  // Immediate-ack load; checks the extended result.
  task automatic load_now(input string tag, input logic [2:0] f3, input logic [31:0] a,
                          input logic [31:0] rdata, input logic [31:0] exp);
    issue(1'b1, 1'b0, f3, a, 32'd0, 5'd7);
    dmem.ack   = 1'b1;
    dmem.rdata = rdata;
    tick();
    dmem.ack   = 1'b0;
    check({tag, "_wbv"}, {31'd0, wb_valid}, 32'd1);
    check({tag, "_data"}, wb_data, exp);
    check({tag, "_rd"}, {27'd0, wb_rd}, 32'd7);
    check({tag, "_exc"}, {31'd0, exc_valid}, 32'd0);
  endtask

  // Faulting op: exception next cycle, no request.
  task automatic fault(input string tag, input logic ld, input logic st,
                       input logic [2:0] f3, input logic [31:0] a);
    issue(ld, st, f3, a, 32'hDEADBEEF, 5'd3);
    check({tag, "_excv"}, {31'd0, exc_valid}, 32'd1);
    check({tag, "_exca"}, exc_addr, a);
    check({tag, "_req"}, {31'd0, dmem.req}, 32'd0);
    check({tag, "_wbv"}, {31'd0, wb_valid}, 32'd0);
    tick();
    check({tag, "_excpulse"}, {31'd0, exc_valid}, 32'd0);
    check({tag, "_req2"}, {31'd0, dmem.req}, 32'd0);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    rst         = 1'b1;
    ex_valid    = 1'b0;
    ex_is_load  = 1'b0;
    ex_is_store = 1'b0;
    ex_funct3   = 3'd0;
    ex_addr     = 32'd0;
    ex_wdata    = 32'd0;
    ex_rd       = 5'd0;
    dmem.ack    = 1'b0;
    dmem.rdata  = 32'd0;

    tick();
    check("rst_ready", {31'd0, ex_ready}, 32'd0);
    check("rst_req", {31'd0, dmem.req}, 32'd0);
    check("rst_wbv", {31'd0, wb_valid}, 32'd0);
    check("rst_excv", {31'd0, exc_valid}, 32'd0);
    rst = 1'b0;
    #1;
    check("rel_ready", {31'd0, ex_ready}, 32'd1);

    // ALU passthrough
    issue(1'b0, 1'b0, 3'b000, 32'h00001234, 32'd0, 5'd5);
    check("alu_wbv", {31'd0, wb_valid}, 32'd1);
    check("alu_data", wb_data, 32'h00001234);
    check("alu_rd", {27'd0, wb_rd}, 32'd5);
    check("alu_req", {31'd0, dmem.req}, 32'd0);
    tick();
    check("alu_pulse", {31'd0, wb_valid}, 32'd0);

    // SB with ack after three request cycles
    issue(1'b0, 1'b1, 3'b000, 32'h00001003, 32'h000000AB, 5'd0);
    check("sb_req", {31'd0, dmem.req}, 32'd1);
    check("sb_we", {31'd0, dmem.we}, 32'd1);
    check("sb_addr", dmem.addr, 32'h00001000);
    check("sb_be", {28'd0, dmem.be}, 32'h8);
    check("sb_wdata", dmem.wdata, 32'hABABABAB);
    check("sb_ready", {31'd0, ex_ready}, 32'd0);
    tick();
    tick();
    check("sb_hold_req", {31'd0, dmem.req}, 32'd1);
    check("sb_hold_wdata", dmem.wdata, 32'hABABABAB);
    dmem.ack = 1'b1;
    tick();
    dmem.ack = 1'b0;
    check("sb_done_req", {31'd0, dmem.req}, 32'd0);
    check("sb_done_ready", {31'd0, ex_ready}, 32'd1);
    check("sb_done_wbv", {31'd0, wb_valid}, 32'd0);
    check("sb_done_exc", {31'd0, exc_valid}, 32'd0);

    // SH upper half and SW lanes
    issue(1'b0, 1'b1, 3'b001, 32'h00001002, 32'h0000BEEF, 5'd0);
    check("sh_be", {28'd0, dmem.be}, 32'hC);
    check("sh_wdata", dmem.wdata, 32'hBEEFBEEF);
    dmem.ack = 1'b1;
    tick();
    dmem.ack = 1'b0;
    issue(1'b0, 1'b1, 3'b010, 32'h00001008, 32'h12345678, 5'd0);
    check("sw_be", {28'd0, dmem.be}, 32'hF);
    check("sw_wdata", dmem.wdata, 32'h12345678);
    dmem.ack = 1'b1;
    tick();
    dmem.ack = 1'b0;

    // Load lane request shape, then extension cases
    issue(1'b1, 1'b0, 3'b000, 32'h00002002, 32'hFFFFFFFF, 5'd9);
    check("lb_be", {28'd0, dmem.be}, 32'h4);
    check("lb_we", {31'd0, dmem.we}, 32'd0);
    check("lb_wdata", dmem.wdata, 32'd0);
    check("lb_addr", dmem.addr, 32'h00002000);
    dmem.ack   = 1'b1;
    dmem.rdata = 32'h00800000;
    tick();
    dmem.ack   = 1'b0;
    check("lb_data", wb_data, 32'hFFFFFF80);
    check("lb_rd", {27'd0, wb_rd}, 32'd9);
    load_now("lbu", 3'b100, 32'h00002002, 32'h00800000, 32'h00000080);
    load_now("lh", 3'b001, 32'h00002002, 32'h80000000, 32'hFFFF8000);
    load_now("lhu", 3'b101, 32'h00002002, 32'h80000000, 32'h00008000);
    load_now("lw", 3'b010, 32'h00002000, 32'h89ABCDEF, 32'h89ABCDEF);
    load_now("lb3", 3'b000, 32'h00002003, 32'h7F000000, 32'h0000007F);

    // Misaligned and illegal ops
    fault("lw_mis", 1'b1, 1'b0, 3'b010, 32'h00002006);
    fault("sh_mis", 1'b0, 1'b1, 3'b001, 32'h00002001);
    fault("ld_f3", 1'b1, 1'b0, 3'b011, 32'h00002000);
    fault("st_f3", 1'b0, 1'b1, 3'b100, 32'h00002000);
    fault("ldst", 1'b1, 1'b1, 3'b010, 32'h00002000);

    // Timeout: req for exactly four cycles, then exception
    issue(1'b1, 1'b0, 3'b010, 32'h00003000, 32'd0, 5'd4);
    for (int i = 0; i < 4; i++) begin
      check("tmo_req_hi", {31'd0, dmem.req}, 32'd1);
      check("tmo_no_exc", {31'd0, exc_valid}, 32'd0);
      tick();
    end
    check("tmo_req_lo", {31'd0, dmem.req}, 32'd0);
    check("tmo_excv", {31'd0, exc_valid}, 32'd1);
    check("tmo_exca", exc_addr, 32'h00003000);
    check("tmo_ready", {31'd0, ex_ready}, 32'd1);
    check("tmo_wbv", {31'd0, wb_valid}, 32'd0);
    tick();
    check("tmo_pulse", {31'd0, exc_valid}, 32'd0);

    // Ack on the fourth cycle beats the timeout
    issue(1'b1, 1'b0, 3'b010, 32'h00003004, 32'd0, 5'd6);
    tick();
    tick();
    tick();
    check("tmo_ack_req", {31'd0, dmem.req}, 32'd1);
    dmem.ack   = 1'b1;
    dmem.rdata = 32'hCAFEF00D;
    tick();
    dmem.ack   = 1'b0;
    check("tmo_ack_wbv", {31'd0, wb_valid}, 32'd1);
    check("tmo_ack_data", wb_data, 32'hCAFEF00D);
    check("tmo_ack_exc", {31'd0, exc_valid}, 32'd0);
    check("tmo_ack_req_lo", {31'd0, dmem.req}, 32'd0);

    // Asynchronous reset while busy
    issue(1'b1, 1'b0, 3'b010, 32'h00004000, 32'd0, 5'd2);
    check("arst_busy_req", {31'd0, dmem.req}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("arst_req", {31'd0, dmem.req}, 32'd0);
    check("arst_wbv", {31'd0, wb_valid}, 32'd0);
    check("arst_excv", {31'd0, exc_valid}, 32'd0);
    check("arst_ready", {31'd0, ex_ready}, 32'd0);
    tick();
    rst = 1'b0;
    #1;
    check("arst_rel_ready", {31'd0, ex_ready}, 32'd1);
    check("arst_no_wb", {31'd0, wb_valid}, 32'd0);
    load_now("post_rst_lw", 3'b010, 32'h00004008, 32'h11223344, 32'h11223344);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

  // Watchdog: a stalled run still reports.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end
endmodule
